reg_file: RTL
=============

# reg_file

Register file directly downstream of the write-back select stage. It captures the selected `write_data` word into one of `2**ADDR_WIDTH` registers on the clock edge. It serves two independent combinational read ports to the ALU operand inputs and tracks which registers have been written since the last reset or clear. Read ports forward same-cycle write data so a consumer never sees a stale value.

## Interface
- `DATA_WIDTH`, default 4: register and data word width.
- `ADDR_WIDTH`, default 2: address width; register count `NREGS = 2**ADDR_WIDTH`.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `we` input 1: write enable, sampled at rising `clk`.
- `clr` input 1: synchronous clear of all registers, sampled at rising `clk`.
- `waddr` input `ADDR_WIDTH`: write address.
- `write_data` input `DATA_WIDTH`: word to write (from write-back select).
- `raddr_a` input `ADDR_WIDTH`: read port A address.
- `raddr_b` input `ADDR_WIDTH`: read port B address.
- `rdata_a` output `DATA_WIDTH`: read port A data.
- `rdata_b` output `DATA_WIDTH`: read port B data.
- `dirty` output `NREGS`: bit i = register i written since last reset/clear.
- `wr_count` output `ADDR_WIDTH+2`: saturating count of accepted writes since last reset/clear.

## Operation
- Reset (`rst`=1, asynchronous, any time): all registers = 0, `dirty` = 0, `wr_count` = 0. Holds while asserted; `we`/`clr` ignored.
- Clear (`clr`=1 at edge): all registers = 0, `dirty` = 0, `wr_count` = 0. `clr` has priority over `we`; a simultaneous write is dropped.
- Write (`we`=1, `clr`=0 at edge): `reg[waddr] <= write_data`; `dirty[waddr] <= 1`; `wr_count` increments by 1, saturating at all-ones (`2**(ADDR_WIDTH+2)-1`, 15 for defaults). Rewriting an already-dirty register still counts.
- Read: `rdata_x = reg[raddr_x]`, combinational.
- Bypass: if `we`=1, `clr`=0 and `raddr_x == waddr`, then `rdata_x = write_data`. Both ports bypass independently; both may hit the same address.
- No bypass during `clr`: reads show stored contents until the edge, then 0.
- All addresses are valid; no out-of-range case exists. There is no hardwired-zero register.

## Timing
- Write latency: 1 cycle. Data is stored at the edge where `we`=1 and visible via storage from the next cycle. It is visible via bypass in the same cycle.
- Read latency: 0 cycles (combinational from `raddr_x`, `we`, `waddr`, `write_data`, `clr`).
- `dirty` and `wr_count` are registered and update at the same edge as the write.
- Reset release: first edge with `rst`=0 performs normal operation.
- Reset asserted mid-cycle while `we`=1: the write is lost; state is 0 immediately.
- All outputs at reset: `rdata_a`/`rdata_b` = 0 unless bypass is active. Bypass cannot be active during reset because the bypass condition ignores `rst`? No: the bypass is gated by `rst`=0, so `rdata_x` = 0 throughout reset. `dirty` = 0, `wr_count` = 0.

## Structure
- Shared datapath package: `DATA_WIDTH` and `ADDR_WIDTH` defaults, derived `NREGS`, and the `wr_count` width constant. These are reused by the write-back select, ALU and control stages.
- Single module; no sub-module. Storage is a register array with one write decoder and two read muxes plus bypass compare.
- Bypass compare is a per-port function or inline logic, not a separate module.

## Test plan
- Reset: assert `rst` with random prior contents -> all reads 0, `dirty`=0000, `wr_count`=0, immediately (before the next edge).
- Write/read: write 0xA to r2, 0x5 to r3; read A=r2, B=r3 next cycle -> `rdata_a`=0xA, `rdata_b`=0x5, `dirty`=1100, `wr_count`=2.
- Bypass: r1 holds 0x3; same cycle `we`=1, `waddr`=1, `write_data`=0xC, `raddr_a`=`raddr_b`=1 -> both read 0xC combinationally; next cycle storage reads 0xC.
- Clear priority: `clr`=1 and `we`=1 to r0 with 0xF, `raddr_a`=0 -> `rdata_a` shows old r0 (no bypass); after the edge all registers 0, `dirty`=0, `wr_count`=0.
- Saturation: 20 consecutive writes -> `wr_count` sticks at 15; a subsequent `clr` returns it to 0.
- Async reset mid-write: `we`=1 to r2 with 0x9, pulse `rst` between edges -> r2 reads 0, `dirty[2]`=0 after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the write-back, register file, ALU and control stages.
// Also holds the per-edge register file operation decode.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 4;
  localparam int unsigned DEF_ADDR_WIDTH    = 2;
  localparam int unsigned RF_NREGS          = 2 ** DEF_ADDR_WIDTH;
  localparam int unsigned RF_WR_COUNT_WIDTH = DEF_ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_STORE,
    WR_CLEAR
  } wr_op_e;

  // Clear always beats write, so a write issued alongside a clear is dropped.
  function automatic wr_op_e decode_op(input logic we, input logic clr);
    if (clr) begin
      return WR_CLEAR;
    end else if (we) begin
      return WR_STORE;
    end
    return WR_IDLE;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: one write port, two combinational read ports with same-cycle
// write bypass, per-register written flags and a saturating write counter.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    clr,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDR_WIDTH-1:0]   raddr_a,
  input  logic [ADDR_WIDTH-1:0]   raddr_b,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  output logic [2**ADDR_WIDTH-1:0] dirty,
  output logic [ADDR_WIDTH+1:0]   wr_count
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  wr_op_e                op;
  logic                  hit_a;
  logic                  hit_b;

  always_comb begin
    op = decode_op(we, clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      dirty    <= '0;
      wr_count <= '0;
    end else begin
      case (op)
        WR_CLEAR: begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
          end
          dirty    <= '0;
          wr_count <= '0;
        end
        WR_STORE: begin
          regs[waddr]  <= write_data;
          dirty[waddr] <= 1'b1;
          if (wr_count != '1) begin
            wr_count <= wr_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bypass is held off during reset so reads stay at zero while rst is high.
  always_comb begin
    hit_a   = (op == WR_STORE) && !rst && (raddr_a == waddr);
    hit_b   = (op == WR_STORE) && !rst && (raddr_b == waddr);
    rdata_a = hit_a ? write_data : regs[raddr_a];
    rdata_b = hit_b ? write_data : regs[raddr_b];
  end

endmodule
